// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants and types for the pipeline stall controller.
package pipe_stall_ctrl_pkg;

  // Default widths for the multi-cycle counter and the per-stage stall vector.
  localparam int unsigned CntW   = 6;
  localparam int unsigned StallW = 6;

  // Stall vector bits: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
  localparam logic [StallW-1:0] StallNone = 6'b000000;
  localparam logic [StallW-1:0] StallId   = 6'b000111;
  localparam logic [StallW-1:0] StallEx   = 6'b001111;

  // Extra EX cycles for the known multi-cycle operations.
  localparam logic [CntW-1:0] MultiCycleLenMadd = 6'd1;
  localparam logic [CntW-1:0] MultiCycleLenDiv  = 6'd33;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall controller.
interface pipe_stall_ctrl_if #(
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned STALL_W = 6
);

  logic               stallreq_id;
  logic               ex_mc_start;
  logic [CNT_W-1:0]   ex_mc_len;
  logic               ex_mc_cancel;
  logic [STALL_W-1:0] stall;
  logic [CNT_W-1:0]   ex_cnt;
  logic               ex_mc_last;
  logic               busy;

  // Pipeline side: raises requests, consumes the stall vector.
  modport master (
    output stallreq_id,
    output ex_mc_start,
    output ex_mc_len,
    output ex_mc_cancel,
    input  stall,
    input  ex_cnt,
    input  ex_mc_last,
    input  busy
  );

  // Controller side.
  modport slave (
    input  stallreq_id,
    input  ex_mc_start,
    input  ex_mc_len,
    input  ex_mc_cancel,
    output stall,
    output ex_cnt,
    output ex_mc_last,
    output busy
  );

endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencing controller: stretches multi-cycle EX ops and merges ID stall requests
// into a per-stage hold vector.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned STALL_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  pipe_stall_ctrl_if.slave bus
);

  state_e             r_state;
  state_e             w_state_d;
  logic [CNT_W-1:0]   r_len;
  logic [CNT_W-1:0]   w_len_d;
  logic [CNT_W-1:0]   r_elapsed;
  logic [CNT_W-1:0]   w_elapsed_d;

  logic               w_start;
  logic [STALL_W-1:0] w_stall;
  logic [CNT_W-1:0]   w_cnt;
  logic               w_last;
  logic               w_busy;

  // A zero-length op is a plain single-cycle EX instruction and never enters RUN.
  assign w_start = bus.ex_mc_start && (bus.ex_mc_len != '0);

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_len     <= '0;
      r_elapsed <= '0;
    end else begin
      r_state   <= w_state_d;
      r_len     <= w_len_d;
      r_elapsed <= w_elapsed_d;
    end
  end

  // Next-state logic and raw outputs; priority is cancel, then EX op, then ID request.
  always_comb begin
    w_state_d   = r_state;
    w_len_d     = r_len;
    w_elapsed_d = r_elapsed;
    w_stall     = STALL_W'(StallNone);
    w_cnt       = '0;
    w_last      = 1'b0;
    w_busy      = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (bus.ex_mc_cancel) begin
          // Aborting an op in the very cycle it would start: release EX at once.
          w_last = w_start;
        end else if (w_start) begin
          // EX stall asserted in the start cycle itself; count begins at 1 next cycle.
          w_stall     = STALL_W'(StallEx);
          w_state_d   = StRun;
          w_len_d     = bus.ex_mc_len;
          w_elapsed_d = CNT_W'(1);
        end else if (bus.stallreq_id) begin
          w_stall = STALL_W'(StallId);
        end
      end

      StRun: begin
        // ex_mc_start is ignored here so the finishing op cannot re-trigger itself.
        w_busy = 1'b1;
        w_cnt  = r_elapsed;
        if (bus.ex_mc_cancel) begin
          w_last      = 1'b1;
          w_state_d   = StIdle;
          w_elapsed_d = '0;
        end else if (r_elapsed < r_len) begin
          w_stall     = STALL_W'(StallEx);
          w_elapsed_d = r_elapsed + CNT_W'(1);
        end else begin
          // Final cycle: EX result advances at the next edge; ID may still hold.
          w_last      = 1'b1;
          w_state_d   = StIdle;
          w_elapsed_d = '0;
          if (bus.stallreq_id) begin
            w_stall = STALL_W'(StallId);
          end
        end
      end

      default: begin
        w_state_d   = StIdle;
        w_elapsed_d = '0;
      end
    endcase
  end

  // Reset forces every output low combinationally, independent of register state.
  always_comb begin
    bus.stall      = '0;
    bus.ex_cnt     = '0;
    bus.ex_mc_last = 1'b0;
    bus.busy       = 1'b0;
    if (!rst) begin
      bus.stall      = w_stall;
      bus.ex_cnt     = w_cnt;
      bus.ex_mc_last = w_last;
      bus.busy       = w_busy;
    end
  end

endmodule
